// File: rtl/interboard_msg_sender_pkg.sv
// interboard_pkg: shared state encoding and GameControl message defaults for the interboard link
package interboard_pkg;
  typedef enum logic [2:0] {RST_SIG, IDLE, LOAD, REQ, REL} ib_state_e;
  localparam int GC_DATA_W = 6;
  localparam int GC_NUM_FIELDS = 6;
  localparam logic [GC_DATA_W-1:0] IB_RST_CODE = '1;
endpackage

// File: rtl/interboard_msg_sender_fifo.sv
// ib_msg_fifo: synchronous message FIFO with registered full/empty flags
module ib_msg_fifo #(
  parameter int W = 36,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt, cnt_n;
  logic do_push, do_pop;
  always_comb begin
    do_push = push && !full;
    do_pop = pop && !empty;
    cnt_n = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      cnt <= cnt_n;
      full <= cnt_n == (AW+1)'(DEPTH);
      empty <= cnt_n == '0;
    end
  end
endmodule

// File: rtl/interboard_msg_sender.sv
// interboard_msg_sender: queues multi-field messages and sends each field over a 4-phase Request/Ack link
module interboard_msg_sender
  import interboard_pkg::*;
#(
  parameter int DATA_W = GC_DATA_W,
  parameter int NUM_FIELDS = GC_NUM_FIELDS,
  parameter int FIFO_DEPTH = 4,
  parameter int RST_HOLD = 10,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         msg_valid,
  input  logic [NUM_FIELDS*DATA_W-1:0] msg_fields,
  output logic                         msg_ready,
  input  logic                         Ack,
  output logic                         Request,
  output logic [DATA_W-1:0]            interboard_data,
  output logic                         busy,
  output logic                         msg_done,
  output logic                         timeout_err
);
  localparam int FW = NUM_FIELDS*DATA_W;
  localparam int IW = NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1;
  localparam int HW = $clog2(RST_HOLD+1);
  localparam int TW = $clog2(ACK_TIMEOUT+2);
  ib_state_e state;
  logic ack_m, ack_s, armed, fifo_empty, fifo_full, last, tmo, req_done, rel_done, pop;
  logic [FW-1:0] shreg, fifo_dout;
  logic [IW-1:0] field_idx;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] wait_cnt;
  ib_msg_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(msg_valid && msg_ready),
    .din(msg_fields),
    .pop(pop),
    .dout(fifo_dout),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  always_comb begin
    msg_ready = !fifo_full && state != RST_SIG;
    busy = state != IDLE || !fifo_empty;
    last = field_idx == IW'(NUM_FIELDS-1);
    tmo = ACK_TIMEOUT != 0 && wait_cnt == TW'(ACK_TIMEOUT) && (state == REQ || state == REL);
    req_done = state == REQ && armed && ack_s;
    rel_done = state == REL && !ack_s;
    pop = (rel_done && last) || (tmo && !req_done && !rel_done);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= Ack;
      ack_s <= ack_m;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_SIG;
      Request <= 1'b1;
      interboard_data <= '1;
      hold_cnt <= '0;
      wait_cnt <= '0;
      field_idx <= '0;
      armed <= 1'b0;
      shreg <= '0;
      msg_done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      msg_done <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        RST_SIG: begin
          if (hold_cnt == HW'(RST_HOLD-1)) begin
            state <= IDLE;
            Request <= 1'b0;
            interboard_data <= '0;
          end else hold_cnt <= hold_cnt + HW'(1);
        end
        IDLE: begin
          if (!fifo_empty) begin
            shreg <= fifo_dout;
            field_idx <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          interboard_data <= shreg[field_idx*DATA_W +: DATA_W];
          wait_cnt <= '0;
          armed <= 1'b0;
          state <= REQ;
        end
        REQ: begin
          if (req_done) begin
            Request <= 1'b0;
            wait_cnt <= '0;
            state <= REL;
          end else if (tmo) begin
            Request <= 1'b0;
            timeout_err <= 1'b1;
            state <= IDLE;
          end else begin
            Request <= 1'b1;
            armed <= armed || !ack_s;
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        REL: begin
          if (rel_done) begin
            msg_done <= last;
            field_idx <= last ? field_idx : field_idx + IW'(1);
            state <= last ? IDLE : LOAD;
          end else if (tmo) begin
            timeout_err <= 1'b1;
            state <= IDLE;
          end else wait_cnt <= wait_cnt + TW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_interboard_msg_sender.sv
// tb_interboard_msg_sender: directed and randomized checks of the interboard sender against a peer model
module tb_interboard_msg_sender;
  localparam int DW = 6;
  localparam int NF = 6;
  localparam int DEP = 4;
  localparam int HOLD = 10;
  localparam int TMO = 20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic msg_valid = 1'b0;
  logic [NF*DW-1:0] msg_fields = '0;
  logic msg_ready, Ack, Request, busy, msg_done, timeout_err;
  logic [DW-1:0] interboard_data;
  int checks = 0;
  int failures = 0;
  int peer_mode = 0;
  bit mon_en = 0;
  int done_cnt = 0;
  int tmo_cnt = 0;
  int stable_err = 0;
  logic [DW-1:0] cap_q[$];
  interboard_msg_sender #(
    .DATA_W(DW), .NUM_FIELDS(NF), .FIFO_DEPTH(DEP), .RST_HOLD(HOLD), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .msg_valid(msg_valid),
    .msg_fields(msg_fields),
    .msg_ready(msg_ready),
    .Ack(Ack),
    .Request(Request),
    .interboard_data(interboard_data),
    .busy(busy),
    .msg_done(msg_done),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  initial begin
    int ph, cnt, dly;
    ph = 0;
    cnt = 0;
    dly = 1;
    Ack = 1'b0;
    forever begin
      @(negedge clk);
      if (peer_mode == 0) begin
        Ack = 1'b0;
        ph = 0;
        cnt = 0;
      end else if (peer_mode == 2) begin
        Ack = 1'b1;
        ph = 0;
        cnt = 0;
      end else if (ph == 0) begin
        Ack = 1'b0;
        if (Request === 1'b1) begin
          if (cnt >= dly) begin
            Ack = 1'b1;
            ph = 1;
            cnt = 0;
            dly = $urandom_range(1, 3);
          end else cnt++;
        end
      end else if (Request === 1'b0) begin
        if (cnt >= dly) begin
          Ack = 1'b0;
          ph = 0;
          cnt = 0;
          dly = $urandom_range(1, 3);
        end else cnt++;
      end
    end
  end
  initial begin
    logic prev_req, cur;
    prev_req = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (msg_done === 1'b1) done_cnt++;
      if (timeout_err === 1'b1) tmo_cnt++;
      if (mon_en && Request === 1'b1 && !prev_req) cap_q.push_back(interboard_data);
      else if (mon_en && Request === 1'b1 && prev_req && interboard_data !== cap_q[$]) stable_err++;
      prev_req = Request === 1'b1;
    end
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_idle(input string tag, input int bound);
    int k = 0;
    while (busy !== 1'b0 && k < bound) begin
      tick();
      k++;
    end
    chk(tag, busy, 0);
  endtask
  task automatic wait_req(input string tag, input int bound);
    int k = 0;
    while (Request !== 1'b1 && k < bound) begin
      tick();
      k++;
    end
    chk(tag, Request, 1);
  endtask
  task automatic cmp_caps(input string tag, input logic [DW-1:0] exp_q[$], input int base);
    int n = cap_q.size() - base;
    chk({tag, "_count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++) chk({tag, "_field"}, cap_q[base+i], exp_q[i]);
    chk({tag, "_stable"}, stable_err, 0);
  endtask
  function automatic logic [NF*DW-1:0] rnd_msg();
    logic [63:0] r = {$urandom(), $urandom()};
    return r[NF*DW-1:0];
  endfunction
  function automatic logic [DW-1:0] fld(input logic [NF*DW-1:0] m, input int i);
    return m[i*DW +: DW];
  endfunction
  initial begin
    logic [DW-1:0] exp_q[$];
    logic [NF*DW-1:0] m, ma, mb;
    int base, d0, t0, n, acc;
    repeat (3) tick();
    chk("rst_request", Request, 1);
    chk("rst_data", interboard_data, 6'h3F);
    chk("rst_ready", msg_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_done", msg_done, 0);
    rst = 1'b0;
    n = 0;
    while (n < 30 && Request === 1'b1 && interboard_data === 6'h3F) begin
      n++;
      tick();
    end
    chk("rst_hold_len", n, HOLD);
    chk("idle_request", Request, 0);
    chk("idle_data", interboard_data, 0);
    chk("idle_ready", msg_ready, 1);
    chk("idle_busy", busy, 0);
    peer_mode = 1;
    mon_en = 1;
    base = cap_q.size();
    d0 = done_cnt;
    m = {6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0};
    msg_valid = 1'b1;
    msg_fields = m;
    tick();
    msg_valid = 1'b0;
    chk("lat_t0_req", Request, 0);
    tick();
    chk("lat_t1_req", Request, 0);
    tick();
    chk("lat_t2_req", Request, 0);
    chk("lat_t2_data", interboard_data, 0);
    tick();
    chk("lat_t3_req", Request, 1);
    wait_idle("single_idle", 400);
    exp_q = {};
    for (int i = 0; i < NF; i++) exp_q.push_back(fld(m, i));
    cmp_caps("single", exp_q, base);
    chk("single_done", done_cnt - d0, 1);
    base = cap_q.size();
    d0 = done_cnt;
    exp_q = {};
    for (int i = 0; i < 5; i++) begin
      m = rnd_msg();
      if (i == 0) m[DW-1:0] = 6'h2A;
      chk("b2b_ready", msg_ready, i < DEP);
      if (msg_ready === 1'b1) for (int f = 0; f < NF; f++) exp_q.push_back(fld(m, f));
      msg_valid = 1'b1;
      msg_fields = m;
      tick();
      if (i == 1) chk("b2b_lat_t1_data", interboard_data, 6'd5);
      if (i == 2) chk("b2b_lat_t2_data", interboard_data, 6'h2A);
      if (i == 3) chk("b2b_lat_t3_req", Request, 1);
    end
    msg_valid = 1'b0;
    chk("b2b_full_ready", msg_ready, 0);
    wait_idle("b2b_idle", 1500);
    cmp_caps("b2b", exp_q, base);
    chk("b2b_done", done_cnt - d0, DEP);
    peer_mode = 0;
    base = cap_q.size();
    d0 = done_cnt;
    t0 = tmo_cnt;
    ma = rnd_msg();
    mb = rnd_msg();
    msg_valid = 1'b1;
    msg_fields = ma;
    tick();
    msg_fields = mb;
    tick();
    msg_valid = 1'b0;
    wait_req("tmo_req_rise", 10);
    n = 0;
    while (n < 60 && Request === 1'b1) begin
      n++;
      tick();
    end
    chk("tmo_req_len", n, TMO);
    peer_mode = 1;
    tick();
    chk("tmo_pulse", tmo_cnt - t0, 1);
    wait_idle("tmo_idle", 400);
    exp_q = {fld(ma, 0)};
    for (int i = 0; i < NF; i++) exp_q.push_back(fld(mb, i));
    cmp_caps("tmo", exp_q, base);
    chk("tmo_done", done_cnt - d0, 1);
    chk("tmo_total", tmo_cnt - t0, 1);
    d0 = done_cnt;
    base = cap_q.size();
    msg_valid = 1'b1;
    msg_fields = rnd_msg();
    tick();
    msg_fields = rnd_msg();
    tick();
    msg_valid = 1'b0;
    n = 0;
    while (n < 300 && cap_q.size() - base < 4) begin
      n++;
      tick();
    end
    chk("midrst_reach_f3", cap_q.size() - base, 4);
    mon_en = 0;
    rst = 1'b1;
    tick();
    chk("midrst_request", Request, 1);
    chk("midrst_data", interboard_data, 6'h3F);
    chk("midrst_ready", msg_ready, 0);
    tick();
    rst = 1'b0;
    wait_idle("midrst_idle", 40);
    chk("midrst_ready_after", msg_ready, 1);
    repeat (10) tick();
    chk("midrst_still_idle", busy, 0);
    chk("midrst_no_done", done_cnt - d0, 0);
    mon_en = 1;
    peer_mode = 2;
    repeat (4) tick();
    base = cap_q.size();
    d0 = done_cnt;
    m = rnd_msg();
    msg_valid = 1'b1;
    msg_fields = m;
    tick();
    msg_valid = 1'b0;
    wait_req("stale_req_rise", 10);
    repeat (5) begin
      tick();
      chk("stale_req_held", Request, 1);
    end
    chk("stale_data", interboard_data, fld(m, 0));
    peer_mode = 1;
    wait_idle("stale_idle", 400);
    exp_q = {};
    for (int i = 0; i < NF; i++) exp_q.push_back(fld(m, i));
    cmp_caps("stale", exp_q, base);
    chk("stale_done", done_cnt - d0, 1);
    base = cap_q.size();
    d0 = done_cnt;
    t0 = tmo_cnt;
    acc = 0;
    exp_q = {};
    for (int c = 0; c < 400; c++) begin
      chk("rnd_ready", msg_ready, (acc - (done_cnt - d0)) < DEP);
      msg_valid = $urandom_range(0, 2) == 0;
      m = rnd_msg();
      msg_fields = m;
      if (msg_valid && msg_ready === 1'b1) begin
        acc++;
        for (int f = 0; f < NF; f++) exp_q.push_back(fld(m, f));
      end
      tick();
    end
    msg_valid = 1'b0;
    wait_idle("rnd_idle", 3000);
    cmp_caps("rnd", exp_q, base);
    chk("rnd_done", done_cnt - d0, acc);
    chk("rnd_no_tmo", tmo_cnt - t0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
